// File: rtl/memory_controller.sv
// Single-word initiator for the asynchronous-strobe memory: sequences CS/WE/OE through
// registered SETUP, ACCESS and HOLD phases and returns one response per accepted request.
module memory_controller #(
  parameter int ADDRESS_SIZE  = 8,
  parameter int WORD_SIZE     = 32,
  parameter int SETUP_CYCLES  = 1,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_we,
  input  logic [ADDRESS_SIZE-1:0] i_req_addr,
  input  logic [WORD_SIZE-1:0]    i_req_wdata,
  output logic                    o_rsp_valid,
  output logic                    o_rsp_err,
  output logic [WORD_SIZE-1:0]    o_rsp_rdata,
  output logic [ADDRESS_SIZE-1:0] o_mem_address,
  output logic [WORD_SIZE-1:0]    o_mem_data,
  output logic                    o_mem_cs,
  output logic                    o_mem_we,
  output logic                    o_mem_oe,
  input  logic [WORD_SIZE-1:0]    i_mem_data,
  output logic [1:0]              o_dbg_state
);

  // Request handshake: a request transfers on a rising edge where i_req_valid && o_req_ready;
  // o_req_ready is high only in IDLE. Responses are single-cycle pulses with no backpressure.

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] ACCESS_LOAD = 8'(ACCESS_CYCLES - 1);

  state_t     state;
  logic [7:0] phase_cnt;
  logic       lat_we;

  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      phase_cnt     <= 8'd0;
      lat_we        <= 1'b0;
      o_req_ready   <= 1'b1;
      o_rsp_valid   <= 1'b0;
      o_rsp_err     <= 1'b0;
      o_rsp_rdata   <= '0;
      o_mem_address <= '0;
      o_mem_data    <= '0;
      o_mem_cs      <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_oe      <= 1'b0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req_valid && o_req_ready) begin
            if (i_req_addr[1:0] != 2'b00) begin
              // Misaligned: answer with an error next cycle and never touch the memory.
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
            end else begin
              state         <= SETUP;
              phase_cnt     <= SETUP_LOAD;
              lat_we        <= i_req_we;
              o_mem_address <= i_req_addr;
              o_mem_data    <= i_req_we ? i_req_wdata : '0;
              o_mem_cs      <= 1'b1;
              o_req_ready   <= 1'b0;
            end
          end
        end
        SETUP: begin
          if (phase_cnt == 8'd0) begin
            state     <= ACCESS;
            phase_cnt <= ACCESS_LOAD;
            o_mem_we  <= lat_we;
            o_mem_oe  <= ~lat_we;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        ACCESS: begin
          if (phase_cnt == 8'd0) begin
            state     <= HOLD;
            phase_cnt <= 8'd0;
            o_mem_we  <= 1'b0;
            o_mem_oe  <= 1'b0;
            if (!lat_we) o_rsp_rdata <= i_mem_data;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        HOLD: begin
          state       <= IDLE;
          phase_cnt   <= 8'd0;
          o_mem_cs    <= 1'b0;
          o_rsp_valid <= 1'b1;
          o_req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: directed vector table, back-to-back and reset-abort sequences,
// then random requests checked cycle by cycle against a byte-array reference model.
module tb_memory_controller;

  localparam int S  = 1;
  localparam int A  = 2;
  localparam int S2 = 2;
  localparam int A2 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // ---------------- default-parameter DUT ----------------
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  mem_address;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_cs, mem_we, mem_oe;
  logic [1:0]  dbg_state;

  memory_controller dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_rdata(rsp_rdata),
    .o_mem_address(mem_address), .o_mem_data(mem_wdata),
    .o_mem_cs(mem_cs), .o_mem_we(mem_we), .o_mem_oe(mem_oe),
    .i_mem_data(mem_rdata), .o_dbg_state(dbg_state)
  );

  // ---------------- SETUP=2 / ACCESS=3 DUT ----------------
  logic        b_valid, b_ready, b_we;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;
  logic        b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic [7:0]  b_mem_address;
  logic [31:0] b_mem_wdata, b_mem_rdata;
  logic        b_mem_cs, b_mem_we, b_mem_oe;
  logic [1:0]  b_dbg_state;

  memory_controller #(.SETUP_CYCLES(S2), .ACCESS_CYCLES(A2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req_we(b_we),
    .i_req_addr(b_addr), .i_req_wdata(b_wdata),
    .o_rsp_valid(b_rsp_valid), .o_rsp_err(b_rsp_err), .o_rsp_rdata(b_rsp_rdata),
    .o_mem_address(b_mem_address), .o_mem_data(b_mem_wdata),
    .o_mem_cs(b_mem_cs), .o_mem_we(b_mem_we), .o_mem_oe(b_mem_oe),
    .i_mem_data(b_mem_rdata), .o_dbg_state(b_dbg_state)
  );

  // ---------------- behavioural strobe memories ----------------
  logic [7:0] mem  [256] = '{default: 8'h00};
  logic [7:0] mem2 [256] = '{default: 8'h00};

  always @(posedge clk) begin
    if (mem_cs && mem_we)
      for (int i = 0; i < 4; i++) mem[8'(mem_address + 8'(i))] <= mem_wdata[8*i +: 8];
    if (b_mem_cs && b_mem_we)
      for (int i = 0; i < 4; i++) mem2[8'(b_mem_address + 8'(i))] <= b_mem_wdata[8*i +: 8];
  end

  always_comb begin
    mem_rdata   = '0;
    b_mem_rdata = '0;
    if (mem_cs && mem_oe)
      for (int i = 0; i < 4; i++) mem_rdata[8*i +: 8] = mem[8'(mem_address + 8'(i))];
    if (b_mem_cs && b_mem_oe)
      for (int i = 0; i < 4; i++) b_mem_rdata[8*i +: 8] = mem2[8'(b_mem_address + 8'(i))];
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [256] = '{default: 8'h00};
  logic [31:0] last_rdata = '0;

  task automatic model_exp(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                           output logic err, output logic [31:0] rdata);
    err = (addr % 4) != 0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < 4; i++) ref_mem[8'(addr + 8'(i))] = wdata[8*i +: 8];
      end else begin
        last_rdata = {ref_mem[8'(addr + 8'd3)], ref_mem[8'(addr + 8'd2)],
                      ref_mem[8'(addr + 8'd1)], ref_mem[addr]};
      end
    end
    rdata = last_rdata;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One request on the default DUT, checked every cycle from acceptance to response.
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata);
    logic [31:0] exp;
    exp_q.push_back(exp_rdata);
    @(negedge clk);
    chk("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = 8'($urandom_range(0, 255));
    req_wdata = $urandom;
    if (exp_err) begin
      exp = exp_q.pop_front();
      chk("err_valid", 32'(rsp_valid), 32'd1);
      chk("err_flag", 32'(rsp_err), 32'd1);
      chk("err_cs", 32'(mem_cs), 32'd0);
      chk("err_ready", 32'(req_ready), 32'd1);
      chk("err_rdata", rsp_rdata, exp);
      @(negedge clk);
      chk("err_pulse", 32'(rsp_valid), 32'd0);
      chk("err_cs_after", 32'(mem_cs), 32'd0);
    end else begin
      for (int k = 1; k <= S + A + 1; k++) begin
        logic in_access;
        in_access = (k > S) && (k <= S + A);
        chk($sformatf("cs_c%0d", k), 32'(mem_cs), 32'd1);
        chk($sformatf("we_c%0d", k), 32'(mem_we), 32'(we && in_access));
        chk($sformatf("oe_c%0d", k), 32'(mem_oe), 32'(!we && in_access));
        chk($sformatf("addr_c%0d", k), 32'(mem_address), 32'(addr));
        chk($sformatf("data_c%0d", k), mem_wdata, we ? wdata : 32'd0);
        chk($sformatf("busy_c%0d", k), {30'd0, req_ready, rsp_valid}, 32'd0);
        @(negedge clk);
      end
      exp = exp_q.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_err", 32'(rsp_err), 32'd0);
      chk("rsp_ready", 32'(req_ready), 32'd1);
      chk("rsp_cs", 32'(mem_cs), 32'd0);
      chk("rsp_rdata", rsp_rdata, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic        m_err;
    logic [31:0] m_rdata;
    int first_rsp, second_rsp;
    logic [31:0] second_rdata;
    logic        ready_at_rsp;

    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[1] = '{1'b0, 8'h10, 32'h00000000, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 8'h13, 32'h00000000, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 8'hFC, 32'h01234567, 1'b0, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 8'hFC, 32'h00000000, 1'b0, 32'h01234567};
    vecs[5] = '{1'b1, 8'h11, 32'h55555555, 1'b1, 32'h01234567};
    vecs[6] = '{1'b0, 8'h20, 32'h00000000, 1'b0, 32'h00000000};

    // ---------------- clock / reset ----------------
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    #23;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_strobes", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_data", mem_wdata, 32'd0);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_cs", 32'(mem_cs), 32'd0);
    chk("post_rst_rsp", 32'(rsp_valid), 32'd0);

    // ---------------- directed vector table ----------------
    for (int i = 0; i < 7; i++) begin
      model_exp(vecs[i].we, vecs[i].addr, vecs[i].wdata, m_err, m_rdata);
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata);
    end
    chk("mem_10", 32'(mem[8'h10]), 32'hEF);
    chk("mem_11", 32'(mem[8'h11]), 32'hBE);
    chk("mem_12", 32'(mem[8'h12]), 32'hAD);
    chk("mem_13", 32'(mem[8'h13]), 32'hDE);
    chk("mem_fc", {mem[8'hFF], mem[8'hFE], mem[8'hFD], mem[8'hFC]}, 32'h01234567);

    // ---------------- back-to-back on SETUP=2 / ACCESS=3 ----------------
    first_rsp = 0; second_rsp = 0; second_rdata = '0; ready_at_rsp = 1'b0;
    @(negedge clk);
    b_valid = 1'b1; b_we = 1'b1; b_addr = 8'h40; b_wdata = 32'hCAFEF00D;
    @(negedge clk);
    b_we = 1'b0; b_wdata = '0;
    for (int c = 1; c <= 30; c++) begin
      if (first_rsp != 0 && c == first_rsp + 1) b_valid = 1'b0;
      if (b_rsp_valid) begin
        if (first_rsp == 0) begin
          first_rsp = c;
          ready_at_rsp = b_ready;
        end else if (second_rsp == 0) begin
          second_rsp = c;
          second_rdata = b_rsp_rdata;
        end
      end
      @(negedge clk);
    end
    b_valid = 1'b0;
    chk("b2b_first_cycle", 32'(first_rsp), 32'(S2 + A2 + 2));
    chk("b2b_ready_at_rsp", 32'(ready_at_rsp), 32'd1);
    chk("b2b_spacing", 32'(second_rsp - first_rsp), 32'(S2 + A2 + 2));
    chk("b2b_rdata", second_rdata, 32'hCAFEF00D);

    // ---------------- reset during write ACCESS ----------------
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h30; req_wdata = 32'hAAAA5555;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_we_before", {30'd0, mem_cs, mem_we}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_strobes_async", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("abort_quiet_%0d", c), {30'd0, rsp_valid, mem_cs}, 32'd0);
      @(negedge clk);
    end
    chk("abort_mem_untouched", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'd0);
    last_rdata = '0;
    chk("abort_rdata_reset", rsp_rdata, 32'd0);
    model_exp(1'b0, 8'h10, 32'd0, m_err, m_rdata);
    do_req(1'b0, 8'h10, 32'd0, m_err, m_rdata);
    chk("abort_readback_model", m_rdata, 32'hDEADBEEF);

    // ---------------- randomized requests vs reference model ----------------
    for (int n = 0; n < 40; n++) begin
      logic        r_we;
      logic [7:0]  r_addr;
      logic [31:0] r_wdata;
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = 8'($urandom_range(0, 63) * 4);
      r_wdata = $urandom;
      if ($urandom_range(0, 4) == 0) r_addr[1:0] = 2'($urandom_range(1, 3));
      model_exp(r_we, r_addr, r_wdata, m_err, m_rdata);
      do_req(r_we, r_addr, r_wdata, m_err, m_rdata);
    end

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
